vc32_mem_arbiter: RTL
=====================

// Module: vc32_mem_arbiter
// PURPOSE
//  Shares the single byte-wide external memory sequencer between two 16-bit requesters.
//  Requester C is the CPU. Requester D is a DMA or debug/boot loader.
//  Sits between both requesters and the sequencer. Presents one request at a time
//  downstream and routes the done pulses back to the owner of the current grant.
//  Round-robin by default. D may lock the bus for short back-to-back bursts.
// PARAMETERS
//  RV          16  data width; only 16 is supported.
//  FIXED_PRI   0   0 = round-robin; 1 = C always wins simultaneous requests.
//  MAX_BURST   4   max consecutive D transactions under d_lock (1..15).
// PORTS
//  clk        in   1   clock
//  r_reset    in   1   reset, synchronous, active-high
//  c_raddr    in   15  C read word address [15:1]
//  c_rreq     in   2   C read byte request: [0]=lo, [1]=hi, 11=word
//  c_rdata    out  16  C read data
//  c_rdone    out  1   C read done pulse
//  c_waddr    in   15  C write word address
//  c_wmask    in   2   C write byte mask
//  c_wdata    in   16  C write data
//  c_wdone    out  1   C write done pulse
//  d_*        same set as c_*, plus:
//  d_lock     in   1   D requests to keep the grant after its current transaction
//  m_raddr    out  15  to sequencer
//  m_rreq     out  2   to sequencer
//  m_rdata    in   16  from sequencer
//  m_rdone    in   1   from sequencer
//  m_waddr    out  15  to sequencer
//  m_wmask    out  2   to sequencer
//  m_wdata    out  16  to sequencer
//  m_wdone    in   1   from sequencer
//  gnt        out  2   current grant, one-hot: [0]=C, [1]=D; for debug
// BEHAVIOUR
//  - Requester pending: |x_wmask or |x_rreq. Requester holds request stable until its done pulse.
//  - States: IDLE, GNT_C, GNT_D, RELEASE.
//  - Reset: state=IDLE, gnt=0, last=D (so C wins first tie), burst count=0.
//    All m_* request outputs 0. c/d done outputs 0.
//  - IDLE:
//    - m_rreq=0, m_wmask=0.
//    - If a single requester is pending, grant it.
//    - If both are pending: when FIXED_PRI=1, C wins; otherwise the one not equal to `last` wins.
//    - Move to GNT_x on the next cycle. Latency from request to m_* valid is one cycle.
//  - GNT_x:
//    - m_raddr, m_rreq, m_waddr, m_wmask, m_wdata = x's inputs, passed combinationally.
//    - The non-granted requester sees done=0.
//  - Done routing:
//    - x_rdone = m_rdone & gnt[x]; x_wdone = m_wdone & gnt[x].
//    - c_rdata = d_rdata = m_rdata, unqualified; valid only with the matching done.
//  - On m_rdone | m_wdone in GNT_x:
//    - Set last=x and go to RELEASE.
//    - Exception: x=D, d_lock=1 and burst count < MAX_BURST-1. Then stay in GNT_D,
//      increment the count, and force m_rreq and m_wmask to 0 for the following cycle
//      (sequencer done-to-idle cycle). D's next request is then forwarded.
//  - RELEASE:
//    - m_rreq=0, m_wmask=0 for exactly one cycle. Covers the sequencer's post-done cycle
//      so a stale request is never re-sampled.
//    - Burst count cleared. Go to IDLE.
//  - Burst boundaries:
//    - At count=MAX_BURST-1, the done forces RELEASE even if d_lock=1.
//    - If C is pending in the next IDLE it then wins (round-robin), so C waits at most
//      MAX_BURST D transactions.
//  - Dropped lock: if d_lock=1 but D drops its request while in GNT_D, after done,
//    hold GNT_D at most 2 idle cycles, then RELEASE.
//  - Done pulse while in IDLE or RELEASE: ignored, no done routed. Flagged by assertion.
//  - Simultaneous request and done: a requester re-requesting in the cycle after its
//    done is arbitrated normally from IDLE.
//  - Reset mid-transaction: returns to IDLE with gnt=0 in one cycle. No done is delivered.
//    The sequencer shares r_reset.
// TESTING
//  - Only C reads word 0x1234>>1:
//    - m_rreq=11 appears 1 cycle later.
//    - c_rdone pulses with m_rdone, c_rdata=m_rdata.
//    - d_rdone stays 0.
//  - C and D request on the same cycle after reset (FIXED_PRI=0):
//    - C granted first, then RELEASE, then D granted.
//    - gnt sequence: 01, 00, 00, 10.
//  - Back-to-back C and D requests held continuously: grants alternate C, D, C, D.
//    No grant is given twice in a row while the other is pending.
//  - D with d_lock=1, MAX_BURST=4, C pending:
//    - D completes 4 writes under one grant.
//    - Then RELEASE, then C is granted.
//  - Byte write D wmask=10, wdata=0xAB00: m_wmask=10, m_wdata=0xAB00.
//    Only d_wdone pulses.
//  - r_reset asserted in GNT_C before done:
//    - Next cycle gnt=0 and all m_ requests are 0.
//    - No c_rdone, even if m_rdone is then forced.

Source files
------------

// File: rtl/vc32_mem_arbiter.sv
// Two-requester arbiter in front of the byte-wide memory sequencer.
// Round-robin or fixed priority; D may hold the grant for short locked bursts.
module vc32_mem_arbiter #(
    parameter int unsigned RV        = 16,
    parameter int unsigned FIXED_PRI = 0,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          r_reset,

    input  logic [RV-2:0] c_raddr,
    input  logic [1:0]    c_rreq,
    output logic [RV-1:0] c_rdata,
    output logic          c_rdone,
    input  logic [RV-2:0] c_waddr,
    input  logic [1:0]    c_wmask,
    input  logic [RV-1:0] c_wdata,
    output logic          c_wdone,

    input  logic [RV-2:0] d_raddr,
    input  logic [1:0]    d_rreq,
    output logic [RV-1:0] d_rdata,
    output logic          d_rdone,
    input  logic [RV-2:0] d_waddr,
    input  logic [1:0]    d_wmask,
    input  logic [RV-1:0] d_wdata,
    output logic          d_wdone,
    input  logic          d_lock,

    output logic [RV-2:0] m_raddr,
    output logic [1:0]    m_rreq,
    input  logic [RV-1:0] m_rdata,
    input  logic          m_rdone,
    output logic [RV-2:0] m_waddr,
    output logic [1:0]    m_wmask,
    output logic [RV-1:0] m_wdata,
    input  logic          m_wdone,

    output logic [1:0]    gnt
);

    localparam int unsigned   BW         = 4;
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_C   = 2'd1,
        GNT_D   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic          last_d, last_d_nx;
    logic [BW-1:0] burst_cnt, burst_cnt_nx;
    logic          gap, gap_nx;
    logic          idle_hold, idle_hold_nx;

    logic c_pend, d_pend, m_done;

    assign c_pend = (|c_wmask) | (|c_rreq);
    assign d_pend = (|d_wmask) | (|d_rreq);
    assign m_done = m_rdone | m_wdone;

    // State register
    always_ff @(posedge clk) begin
        if (r_reset) begin
            state     <= IDLE;
            last_d    <= 1'b1;
            burst_cnt <= '0;
            gap       <= 1'b0;
            idle_hold <= 1'b0;
        end else begin
            state     <= state_nx;
            last_d    <= last_d_nx;
            burst_cnt <= burst_cnt_nx;
            gap       <= gap_nx;
            idle_hold <= idle_hold_nx;
        end
    end

    // Next-state: arbitration, burst continuation and dropped-lock timeout
    always_comb begin
        state_nx     = state;
        last_d_nx    = last_d;
        burst_cnt_nx = burst_cnt;
        gap_nx       = 1'b0;
        idle_hold_nx = 1'b0;
        case (state)
            IDLE: begin
                if (c_pend && d_pend)
                    state_nx = ((FIXED_PRI != 0) || last_d) ? GNT_C : GNT_D;
                else if (c_pend)
                    state_nx = GNT_C;
                else if (d_pend)
                    state_nx = GNT_D;
            end
            GNT_C: begin
                if (m_done) begin
                    last_d_nx = 1'b0;
                    state_nx  = RELEASE;
                end
            end
            GNT_D: begin
                if (m_done) begin
                    if (d_lock && (burst_cnt < BURST_LAST)) begin
                        burst_cnt_nx = burst_cnt + BW'(1);
                        gap_nx       = 1'b1;
                    end else begin
                        last_d_nx = 1'b1;
                        state_nx  = RELEASE;
                    end
                end else if (!d_pend) begin
                    // D let go of a locked grant: give it two idle cycles at most
                    if (idle_hold) begin
                        last_d_nx = 1'b1;
                        state_nx  = RELEASE;
                    end else begin
                        idle_hold_nx = 1'b1;
                    end
                end
            end
            RELEASE: begin
                burst_cnt_nx = '0;
                state_nx     = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Downstream mux; requests are masked outside a grant and in the burst gap cycle
    always_comb begin
        m_raddr = '0;
        m_rreq  = '0;
        m_waddr = '0;
        m_wmask = '0;
        m_wdata = '0;
        if (state == GNT_C) begin
            m_raddr = c_raddr;
            m_rreq  = c_rreq;
            m_waddr = c_waddr;
            m_wmask = c_wmask;
            m_wdata = c_wdata;
        end else if (state == GNT_D) begin
            m_raddr = d_raddr;
            m_waddr = d_waddr;
            m_wdata = d_wdata;
            if (!gap) begin
                m_rreq  = d_rreq;
                m_wmask = d_wmask;
            end
        end
    end

    assign gnt     = {state == GNT_D, state == GNT_C};
    assign c_rdone = m_rdone & gnt[0];
    assign c_wdone = m_wdone & gnt[0];
    assign d_rdone = m_rdone & gnt[1];
    assign d_wdone = m_wdone & gnt[1];
    assign c_rdata = m_rdata;
    assign d_rdata = m_rdata;

    // A done outside a grant is dropped; it indicates a sequencer fault
    a_done_in_grant: assert property (@(posedge clk) disable iff (r_reset)
        (m_rdone || m_wdone) |-> (state == GNT_C || state == GNT_D));

endmodule
